sisc_exec_ctrl: RTL and testbench

Combined control, ALU and branch-address block of the SISC processor core. It holds the multi-cycle instruction sequencer and decodes the instruction-register fields into the register-file, PC and IR strobes. It computes ALU results and status flags, and forms the branch target handed to the PC. It sits between the IR/register file/status register on the input side and the PC, register-file write port and status register on the output side.

---
 rtl/sisc_pkg.sv | 34 +++
 rtl/sisc_alu_core.sv | 30 +++
 rtl/sisc_exec_ctrl.sv | 122 ++++++++++++
 tb/tb_sisc_exec_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared opcodes, sequencer states, alu_op fields and status bit indices
package sisc_pkg;

  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_ALU_REG = 4'b0001;
  localparam logic [3:0] OP_ALU_IMM = 4'b0010;
  localparam logic [3:0] OP_BRA     = 4'b0100;
  localparam logic [3:0] OP_BRR     = 4'b0101;
  localparam logic [3:0] OP_BNE     = 4'b0110;
  localparam logic [3:0] OP_BNR     = 4'b0111;
  localparam logic [3:0] OP_HLT     = 4'b1111;

  typedef enum logic [2:0] {
    S_START0,
    S_START1,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  // alu_op[1] selects subtract, alu_op[0] selects the sign-extended immediate
  localparam int ALU_OP_SUB = 1;
  localparam int ALU_OP_IMM = 0;

  // Status vector layout {C,V,N,Z}
  localparam int STS_C = 3;
  localparam int STS_V = 2;
  localparam int STS_N = 1;
  localparam int STS_Z = 0;

endpackage

// File: rtl/sisc_alu_core.sv
// rtl/sisc_alu_core.sv - combinational add/subtract with {C,V,N,Z} flags
module sisc_alu_core
  import sisc_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b_reg,
  input  logic [15:0] imm,
  output logic [31:0] result,
  output logic [3:0]  sts
);

  logic [31:0] b_sel;
  logic [31:0] b_eff;
  logic [32:0] sum;

  // Subtract is A + ~B + 1 so C reads as "no borrow" for subtraction
  always_comb begin
    b_sel  = alu_op[ALU_OP_IMM] ? {{16{imm[15]}}, imm} : b_reg;
    b_eff  = alu_op[ALU_OP_SUB] ? ~b_sel : b_sel;
    sum    = {1'b0, a} + {1'b0, b_eff} + {32'd0, alu_op[ALU_OP_SUB]};
    result = sum[31:0];
    sts        = 4'b0000;
    sts[STS_C] = sum[32];
    sts[STS_V] = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    sts[STS_N] = sum[31];
    sts[STS_Z] = (sum[31:0] == 32'd0);
  end

endmodule

// File: rtl/sisc_exec_ctrl.sv
// rtl/sisc_exec_ctrl.sv - SISC sequencer, instruction decode, ALU and branch target
module sisc_exec_ctrl
  import sisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_f,
  input  logic [31:0] ir,
  input  logic [3:0]  stat,
  input  logic [31:0] rega,
  input  logic [31:0] regb,
  input  logic [15:0] pc_in,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        rb_sel,
  output logic [1:0]  alu_op,
  output logic        br_sel,
  output logic        pc_rst,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        ir_load,
  output logic [31:0] alu_out,
  output logic [3:0]  alu_sts,
  output logic        stat_en,
  output logic [15:0] br_addr
);

  state_t      state, state_nxt;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic        is_alu;
  logic        br_taken;
  logic        cond;

  assign opcode = ir[31:28];
  assign mm     = ir[27:24];
  assign imm    = ir[15:0];
  assign cond   = |(stat & mm);

  // rd/rs fields address the register file outside this block
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir[23:16];

  assign wb_sel = 1'b0;
  assign rb_sel = 1'b0;

  // Opcode classification: ALU ops, branch condition polarity and target mode
  always_comb begin
    is_alu   = 1'b0;
    br_taken = 1'b0;
    br_sel   = 1'b0;
    alu_op   = 2'b00;
    case (opcode)
      OP_ALU_REG: begin is_alu = 1'b1; alu_op = {mm[0], 1'b0}; end
      OP_ALU_IMM: begin is_alu = 1'b1; alu_op = {mm[0], 1'b1}; end
      OP_BRA:     begin br_taken = cond;  br_sel = 1'b1; end
      OP_BRR:     begin br_taken = cond;  end
      OP_BNE:     begin br_taken = ~cond; br_sel = 1'b1; end
      OP_BNR:     begin br_taken = ~cond; end
      OP_NOP, OP_HLT: ;
      default: ;
    endcase
  end

  // Branch target: absolute immediate or PC-relative, wrapping at 16 bits
  assign br_addr = br_sel ? imm : (pc_in + imm);

  sisc_alu_core u_alu (
    .alu_op (alu_op),
    .a      (rega),
    .b_reg  (regb),
    .imm    (imm),
    .result (alu_out),
    .sts    (alu_sts)
  );

  // Sequencer state register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= S_START0;
    else        state <= state_nxt;
  end

  // Next-state and per-state strobes
  always_comb begin
    state_nxt = state;
    pc_rst    = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    ir_load   = 1'b0;
    stat_en   = 1'b0;
    rf_we     = 1'b0;
    case (state)
      S_START0: begin
        pc_rst    = 1'b1;
        state_nxt = S_START1;
      end
      S_START1: state_nxt = S_FETCH;
      S_FETCH: begin
        ir_load   = 1'b1;
        pc_write  = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        pc_write  = br_taken;
        pc_sel    = br_taken;
        state_nxt = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        stat_en   = is_alu;
        state_nxt = S_MEM;
      end
      S_MEM: state_nxt = S_WRITEBACK;
      S_WRITEBACK: begin
        rf_we     = is_alu;
        state_nxt = S_FETCH;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_START0;
    endcase
  end

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// tb/tb_sisc_exec_ctrl.sv - scoreboard bench for sisc_exec_ctrl
module tb_sisc_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [31:0] ir;
  logic [3:0]  stat;
  logic [31:0] rega;
  logic [31:0] regb;
  logic [15:0] pc_in;
  logic        rf_we, wb_sel, rb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load, stat_en;
  logic [1:0]  alu_op;
  logic [31:0] alu_out;
  logic [3:0]  alu_sts;
  logic [15:0] br_addr;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  // Strobe order {pc_rst, ir_load, pc_write, pc_sel, stat_en, rf_we}
  logic [5:0] strobes;
  assign strobes = {pc_rst, ir_load, pc_write, pc_sel, stat_en, rf_we};

  localparam logic [5:0] ST_IDLE   = 6'b000000;
  localparam logic [5:0] ST_RESET  = 6'b100000;
  localparam logic [5:0] ST_FETCH  = 6'b011000;
  localparam logic [5:0] ST_BRANCH = 6'b001100;
  localparam logic [5:0] ST_STAT   = 6'b000010;
  localparam logic [5:0] ST_WE     = 6'b000001;

  always #5 clk = ~clk;

  sisc_exec_ctrl dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .ir       (ir),
    .stat     (stat),
    .rega     (rega),
    .regb     (regb),
    .pc_in    (pc_in),
    .rf_we    (rf_we),
    .wb_sel   (wb_sel),
    .rb_sel   (rb_sel),
    .alu_op   (alu_op),
    .br_sel   (br_sel),
    .pc_rst   (pc_rst),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .ir_load  (ir_load),
    .alu_out  (alu_out),
    .alu_sts  (alu_sts),
    .stat_en  (stat_en),
    .br_addr  (br_addr)
  );

  task automatic push(input string tag, input logic [31:0] value);
    tag_q.push_back(tag);
    exp_q.push_back(value);
  endtask

  task automatic pop_check(input logic [31:0] observed);
    logic [31:0] expected;
    string       tag;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h expected=none", observed);
      return;
    end
    expected = exp_q.pop_front();
    tag      = tag_q.pop_front();
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step_strobes(input string tag, input logic [5:0] exp_st);
    push(tag, {26'd0, exp_st});
    @(negedge clk);
    pop_check({26'd0, strobes});
  endtask

  task automatic fetch_decode(input logic [31:0] instr, input string tag, input logic [5:0] dec_st);
    ir = instr;
    step_strobes({tag, "_fetch"}, ST_FETCH);
    step_strobes({tag, "_decode"}, dec_st);
  endtask

  task automatic exec_rest(input string tag, input logic [5:0] ex_st, input logic [5:0] wb_st);
    step_strobes({tag, "_execute"}, ex_st);
    step_strobes({tag, "_mem"}, ST_IDLE);
    step_strobes({tag, "_writeback"}, wb_st);
  endtask

  initial begin
    rst_f = 1'b0;
    ir    = 32'h0;
    stat  = 4'h0;
    rega  = 32'h0;
    regb  = 32'h0;
    pc_in = 16'h0;

    // Reset held low
    repeat (2) @(negedge clk);
    push("reset_strobes", {26'd0, ST_RESET});
    pop_check({26'd0, strobes});
    push("reset_alu_op", 32'd0);
    pop_check({30'd0, alu_op});
    push("wb_rb_sel", 32'd0);
    pop_check({30'd0, wb_sel, rb_sel});

    rst_f = 1'b1;
    step_strobes("start1", ST_IDLE);

    // ALU reg add: 5 + 7
    rega = 32'd5;
    regb = 32'd7;
    fetch_decode(32'h10123000, "add", ST_IDLE);
    push("add_alu_op", 32'd0);
    pop_check({30'd0, alu_op});
    push("add_out", 32'd12);
    pop_check(alu_out);
    push("add_sts", 32'h0);
    pop_check({28'd0, alu_sts});
    exec_rest("add", ST_STAT, ST_WE);

    // ALU reg sub: 5 - 7 borrows, negative
    fetch_decode(32'h11123000, "subr", ST_IDLE);
    push("subr_alu_op", 32'd2);
    pop_check({30'd0, alu_op});
    push("subr_out", 32'hFFFF_FFFE);
    pop_check(alu_out);
    push("subr_sts", 32'h2);
    pop_check({28'd0, alu_sts});
    exec_rest("subr", ST_STAT, ST_WE);

    // ALU imm sub: 5 - 5 gives zero with no borrow
    fetch_decode(32'h21120005, "subi", ST_IDLE);
    push("subi_alu_op", 32'd3);
    pop_check({30'd0, alu_op});
    push("subi_out", 32'h0);
    pop_check(alu_out);
    push("subi_sts", 32'h9);
    pop_check({28'd0, alu_sts});
    ir   = 32'h21120001;
    rega = 32'h8000_0000;
    #1;
    push("subi_ovf_out", 32'h7FFF_FFFF);
    pop_check(alu_out);
    push("subi_ovf_sts", 32'hC);
    pop_check({28'd0, alu_sts});
    exec_rest("subi", ST_STAT, ST_WE);

    // BRA on Z with Z set: taken, absolute target
    stat = 4'b0001;
    fetch_decode(32'h41000010, "bra", ST_BRANCH);
    push("bra_br_sel", 32'd1);
    pop_check({31'd0, br_sel});
    push("bra_br_addr", 32'h0010);
    pop_check({16'd0, br_addr});
    exec_rest("bra", ST_IDLE, ST_IDLE);

    // BNR on Z with Z set: not taken
    pc_in = 16'hFFFF;
    fetch_decode(32'h71000002, "bnr_nt", ST_IDLE);
    push("bnr_br_sel", 32'd0);
    pop_check({31'd0, br_sel});
    exec_rest("bnr_nt", ST_IDLE, ST_IDLE);

    // BNR with Z clear: taken, relative target wraps
    stat = 4'b0000;
    fetch_decode(32'h71000002, "bnr_t", ST_BRANCH);
    push("bnr_br_addr", 32'h0001);
    pop_check({16'd0, br_addr});
    exec_rest("bnr_t", ST_IDLE, ST_IDLE);

    // Reset during EXECUTE of an ALU op suppresses stat_en and rf_we
    rega = 32'd1;
    fetch_decode(32'h10123000, "abort", ST_IDLE);
    @(posedge clk);
    #2;
    rst_f = 1'b0;
    #1;
    push("abort_async", {26'd0, ST_RESET});
    pop_check({26'd0, strobes});
    step_strobes("abort_hold", ST_RESET);
    rst_f = 1'b1;
    step_strobes("abort_start1", ST_IDLE);

    // HLT: sequencer parks with no fetch activity
    fetch_decode(32'hF0000000, "hlt", ST_IDLE);
    for (int i = 0; i < 6; i++) step_strobes("halt_idle", ST_IDLE);
    rst_f = 1'b0;
    #1;
    push("halt_reset", {26'd0, ST_RESET});
    pop_check({26'd0, strobes});
    rst_f = 1'b1;
    step_strobes("post_halt_start1", ST_IDLE);
    step_strobes("post_halt_fetch", ST_FETCH);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
